vga_line_fetch: RTL and testbench
=================================

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter DEPTH, default 16, pixel FIFO entries (power of two, >=4).
REQ-004 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-low reset.
REQ-006 SHALL have port VGA_BLANK  in  1  from timing generator; 1 = active pixel this cycle.
REQ-007 SHALL have port VGA_VS  in  1  from timing generator; active-low vertical sync.
REQ-008 SHALL have port MEM_REQ  out  1  framebuffer read request.
REQ-009 SHALL have port MEM_ADDR  out  AW=$clog2(HDISP*VDISP)  pixel address; stable while MEM_REQ=1 and MEM_ACK=0.
REQ-010 SHALL have port MEM_ACK  in  1  request accepted in a cycle with MEM_REQ=1 and MEM_ACK=1.
REQ-011 SHALL have port MEM_RVALID  in  1  read data valid; responses are returned in order, at least 1 cycle after the accepting cycle.
REQ-012 SHALL have port MEM_RDATA  in  24  pixel as {R,G,B}.
REQ-013 SHALL have ports VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
REQ-014 SHALL have port UNDERFLOW  out  1  sticky flag: a pixel was needed and the FIFO was empty.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, FILL.
REQ-016 SHALL go from IDLE to FLUSH on the first cycle after reset in which VGA_VS is 0 and was 1 in the previous cycle (a VS falling edge).
REQ-017 SHALL, on any VS falling edge in any state, set addr=0, empty the FIFO and enter FLUSH.
REQ-018 SHALL stay in FLUSH until outstanding=0, discarding MEM_RDATA; it SHALL then enter FILL.
REQ-019 SHALL track outstanding requests in a counter of width $clog2(DEPTH+1): +1 on accept, -1 on MEM_RVALID, unchanged when both occur in the same cycle.
REQ-020 SHALL assert MEM_REQ in FILL only when fifo_count+outstanding < DEPTH, and SHALL never assert it in IDLE or FLUSH.
REQ-021 SHALL increment addr on each accept; addr HDISP*VDISP-1 SHALL wrap to 0.
REQ-022 SHALL, in FILL, push MEM_RDATA into the FIFO on MEM_RVALID.
REQ-023 SHALL ignore MEM_RVALID when outstanding=0, with no change to the counter or the FIFO.
REQ-024 SHALL, when VGA_BLANK=1 and the FIFO is non-empty, drive VGA_R/G/B combinationally from the FIFO head and pop that entry at the clock edge.
REQ-025 SHALL, when VGA_BLANK=0, drive VGA_R/G/B to 0 and not pop.
REQ-026 SHALL, when VGA_BLANK=1 and the FIFO is empty, not pop, drive the underflow colour (see Configuration) and set UNDERFLOW=1 at the next edge.
REQ-027 SHALL leave fifo_count unchanged when a push and a pop occur in the same cycle; a push and a pop on a full FIFO SHALL be legal.
REQ-028 SHALL make a VS falling edge take priority over a simultaneous push, pop or accept; in that case outstanding SHALL still count the accept and the RVALID.

Reset
REQ-029 SHALL, on RST=0 at a clock edge, set state=IDLE, addr=0, fifo_count=0, outstanding=0, UNDERFLOW=0 and the VS history register to 1.
REQ-030 SHALL drive MEM_REQ=0 and VGA_R/G/B=0 (when VGA_BLANK=0) from the first edge with RST=0.
REQ-031 SHALL, when reset occurs mid-transfer, discard responses to earlier requests: the counter is 0, so they are ignored per REQ-023.
REQ-032 SHALL clear UNDERFLOW only by reset.

Configuration
REQ-033 SHALL use macro VGA_FETCH_UNDERFLOW_COLOR_EN.
REQ-034 SHALL, when the macro is defined, drive the underflow colour as R=8'hFF, G=8'h00, B=8'hFF (magenta).
REQ-035 SHALL, when the macro is not defined, drive the underflow colour as R=G=B=0; UNDERFLOW behaviour is identical in both builds.

Verification
REQ-036 SHALL test: reset, then a VS falling edge, memory with ACK=1 and 2-cycle latency, DATA=addr -> addresses 0,1,2...; first active pixel RGB=0x000000, pixel n = n; UNDERFLOW=0 after a full 640x480 frame.
REQ-037 SHALL test: hold MEM_ACK=0 for 3 cycles with REQ=1 -> MEM_ADDR stays constant, outstanding unchanged, no address skipped.
REQ-038 SHALL test: stall RVALID until the FIFO drains, with BLANK=1 -> RGB=0xFF00FF (macro on) or 0x000000 (macro off), UNDERFLOW=1 and sticky through the next frame.
REQ-039 SHALL test: a VS falling edge with 5 requests outstanding -> those 5 responses are discarded, the first request after FLUSH has MEM_ADDR=0 and the next frame's pixel 0 is 0.
REQ-040 SHALL test: addr at 307199 accepted -> next MEM_ADDR=0.
REQ-041 SHALL test: RST=0 for one cycle mid-line, then a stale RVALID arrives -> it is ignored, state=IDLE, MEM_REQ=0 until the next VS falling edge.

Source files
------------

// File: rtl/vga_line_fetch.sv
// vga_line_fetch -- prefetches framebuffer pixels into a small FIFO ahead of the
// VGA scan-out and presents them on VGA_R/G/B while the timing generator
// flags an active pixel.
//
// Ports
//   CLK          sole clock, rising edge
//   RST          synchronous active-low reset
//   VGA_BLANK    1 = active pixel this cycle (pop from FIFO head)
//   VGA_VS       active-low vertical sync; a falling edge restarts the frame
//   MEM_REQ      read request, held with a stable MEM_ADDR until MEM_ACK
//   MEM_ADDR     pixel address, wraps at HDISP*VDISP-1
//   MEM_ACK      request accepted when MEM_REQ & MEM_ACK
//   MEM_RVALID   in-order read response strobe
//   MEM_RDATA    {R,G,B} response data
//   VGA_R/G/B    pixel colour (0 outside the active area)
//   UNDERFLOW    sticky: an active pixel found the FIFO empty (reset-only clear)
//
// Build option: define VGA_FETCH_UNDERFLOW_COLOR_EN to show magenta instead of
// black on an underflowed pixel.
module vga_line_fetch #(
   parameter int HDISP = 640,
   parameter int VDISP = 480,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(HDISP*VDISP)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VGA_BLANK,
   input  logic          VGA_VS,
   output logic          MEM_REQ,
   output logic [AW-1:0] MEM_ADDR,
   input  logic          MEM_ACK,
   input  logic          MEM_RVALID,
   input  logic [23:0]   MEM_RDATA,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          UNDERFLOW
);

   localparam int NPIX = HDISP*VDISP;
   localparam int CW   = $clog2(DEPTH+1);
   localparam int PW   = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);
   localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX-1);

`ifdef VGA_FETCH_UNDERFLOW_COLOR_EN
   localparam logic [23:0] UF_COLOR = 24'hFF00FF;
`else
   localparam logic [23:0] UF_COLOR = 24'h000000;
`endif

   typedef enum logic [1:0] {IDLE, FLUSH, FILL} state_t;

   state_t        state_q, state_d;
   logic          vs_q;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic          uf_q, uf_d;
   logic [23:0]   fifo_q [DEPTH];
   logic [23:0]   pix;

   logic vs_fall, accept, rv_ok, fifo_empty, push, pop;

   assign vs_fall    = vs_q & ~VGA_VS;
   assign fifo_empty = (cnt_q == '0);

   // Requests are throttled so every in-flight response is guaranteed a slot.
   assign MEM_REQ  = (state_q == FILL) && (({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_C);
   assign accept   = MEM_REQ & MEM_ACK;
   // A response with nothing outstanding belongs to a request issued before
   // reset; it is dropped entirely.
   assign rv_ok    = MEM_RVALID & (outst_q != '0);
   // Responses seen in FLUSH (or on the VS edge) only retire the counter.
   assign push     = (state_q == FILL) & rv_ok & ~vs_fall;
   assign pop      = VGA_BLANK & ~fifo_empty & ~vs_fall;

   assign MEM_ADDR  = addr_q;
   assign UNDERFLOW = uf_q;

   // Next state: a VS falling edge restarts from FLUSH regardless of state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         FLUSH:   if (outst_q == '0) state_d = FILL;
         FILL:    state_d = FILL;
         default: state_d = IDLE;
      endcase
      if (vs_fall) state_d = FLUSH;
   end

   // Datapath next-state.
   always_comb begin
      outst_d = outst_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      uf_d    = uf_q | (VGA_BLANK & fifo_empty);

      // The counter keeps tracking across a VS edge so FLUSH knows how many
      // stale responses are still on their way.
      if (accept && !rv_ok)      outst_d = outst_q + CW'(1);
      else if (!accept && rv_ok) outst_d = outst_q - CW'(1);

      if (accept) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
      if (push)   wr_d   = wr_q + PW'(1);
      if (pop)    rd_d   = rd_q + PW'(1);

      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);

      if (vs_fall) begin
         addr_d = '0;
         wr_d   = '0;
         rd_d   = '0;
         cnt_d  = '0;
      end
   end

   // Colour: head of FIFO on active pixels, underflow colour when empty.
   always_comb begin
      pix = '0;
      if (VGA_BLANK) pix = fifo_empty ? UF_COLOR : fifo_q[rd_q];
   end

   assign {VGA_R, VGA_G, VGA_B} = pix;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         vs_q    <= 1'b1;
         addr_q  <= '0;
         outst_q <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_q    <= VGA_VS;
         addr_q  <= addr_d;
         outst_q <= outst_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         uf_q    <= uf_d;
      end
   end

   // Pixel storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_q] <= MEM_RDATA;
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomised bench for vga_line_fetch with a queue-level reference model:
// expected addresses, an expected pixel FIFO and counts of live/stale reads.
module tb_vga_line_fetch;

   localparam int HD   = 12;
   localparam int VD   = 10;
   localparam int DP   = 8;
   localparam int NPIX = HD*VD;
   localparam int AW   = $clog2(NPIX);
   localparam int LAT  = 2;

`ifdef VGA_FETCH_UNDERFLOW_COLOR_EN
   localparam logic [23:0] UFC = 24'hFF00FF;
`else
   localparam logic [23:0] UFC = 24'h000000;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          VGA_BLANK = 1'b0;
   logic          VGA_VS = 1'b1;
   logic          MEM_REQ;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_ACK = 1'b0;
   logic          MEM_RVALID = 1'b0;
   logic [23:0]   MEM_RDATA = '0;
   logic [7:0]    VGA_R, VGA_G, VGA_B;
   logic          UNDERFLOW;

   vga_line_fetch #(.HDISP(HD), .VDISP(VD), .DEPTH(DP)) dut (
      .CLK(CLK), .RST(RST), .VGA_BLANK(VGA_BLANK), .VGA_VS(VGA_VS),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
      .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct {int dut; int exp; int due; bit stale;} rd_t;
   rd_t memq[$];
   int  cyc = 0;
   bit  ack_force0 = 0, ack_rand = 0, rv_hold = 0, rv_rand = 0, inject_rv = 0;
   bit  cur_stale = 0;
   int  cur_exp = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      rd_t e;
      #2;
      MEM_ACK    = ack_force0 ? 1'b0 : (ack_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 24'($urandom);
      if (!RST) memq.delete();
      else if (inject_rv) begin
         MEM_RVALID = 1'b1;
         cur_stale  = 1'b1;
         inject_rv  = 1'b0;
      end else if (!rv_hold && memq.size() != 0 && memq[0].due <= cyc &&
                   (!rv_rand || $urandom_range(0, 1) == 1)) begin
         e = memq.pop_front();
         MEM_RVALID = 1'b1;
         MEM_RDATA  = 24'(e.dut);
         cur_stale  = e.stale;
         cur_exp    = e.exp;
      end
   end

   // ---------------- reference model + monitor ----------------
   logic [23:0] fq[$];
   int  exp_addr = 0, fresh_cnt = 0, flush_cnt = 0;
   bit  idle = 1, in_flush = 0, uf_exp = 0, vs_prev = 1, rst_prev = 0;
   bit  pstall = 0;
   logic [AW-1:0] paddr = '0;
   bit  watch_first = 0;
   int  first_acc = -1;

   always @(negedge CLK) begin
      logic [23:0] exp_rgb;
      bit vsf, emp, pop;
      int fl_pre;
      if (!RST) begin
         if (rst_prev) begin
            chk("rst_req", 32'(MEM_REQ), 0);
            chk("rst_uf", 32'(UNDERFLOW), 0);
            chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
         end
         fq.delete();
         exp_addr = 0; fresh_cnt = 0; flush_cnt = 0;
         idle = 1; in_flush = 0; uf_exp = 0; vs_prev = 1; pstall = 0; rst_prev = 1;
      end else begin
         rst_prev = 0;
         vsf = vs_prev && !VGA_VS;
         vs_prev = VGA_VS;
         emp = (fq.size() == 0);
         exp_rgb = !VGA_BLANK ? 24'h0 : (emp ? UFC : fq[0]);
         chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb});
         chk("uf", 32'(UNDERFLOW), 32'(uf_exp));
         if (idle || in_flush) chk("req_off", 32'(MEM_REQ), 0);
         else chk("req", 32'(MEM_REQ), 32'(fq.size() + fresh_cnt < DP));
         if (pstall) begin
            chk("stall_req", 32'(MEM_REQ), 1);
            chk("stall_addr", 32'(MEM_ADDR), 32'(paddr));
         end
         pstall = MEM_REQ && !MEM_ACK && !vsf;
         paddr  = MEM_ADDR;
         fl_pre = flush_cnt;

         if (MEM_RVALID) begin
            if (cur_stale) begin
               if (flush_cnt > 0) flush_cnt--;
            end else fresh_cnt--;
         end
         pop = VGA_BLANK && !emp && !vsf;
         if (VGA_BLANK && emp) uf_exp = 1;
         if (pop) void'(fq.pop_front());
         if (MEM_RVALID && !cur_stale && !vsf) fq.push_back(24'(cur_exp));

         if (MEM_REQ && MEM_ACK) begin
            chk("addr", 32'(MEM_ADDR), 32'(exp_addr));
            if (watch_first) begin
               first_acc = int'(MEM_ADDR);
               watch_first = 0;
            end
            memq.push_back('{int'(MEM_ADDR), exp_addr, cyc + LAT, vsf});
            exp_addr = (exp_addr + 1) % NPIX;
            if (vsf) flush_cnt++;
            else fresh_cnt++;
         end

         if (vsf) begin
            fq.delete();
            exp_addr = 0;
            flush_cnt += fresh_cnt;
            fresh_cnt = 0;
            foreach (memq[i]) memq[i].stale = 1;
            in_flush = 1;
            idle = 0;
         end else if (in_flush && fl_pre == 0) in_flush = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc1(input bit blank, input bit vs);
      @(posedge CLK);
      #1;
      VGA_BLANK = blank;
      VGA_VS    = vs;
   endtask

   task automatic lines(input int n);
      for (int l = 0; l < n; l++) begin
         repeat (HD) cyc1(1, 1);
         repeat (4) cyc1(0, 1);
      end
   endtask

   // One frame: VS pulse, porch, VD active lines. Optional hooks:
   // stall -> MEM_ACK held low for 3 porch cycles; px0 -> check first pixel;
   // flush5 -> release held responses after the VS edge and watch first req;
   // ufl -> withhold responses during the first active line.
   task automatic frame(input bit stall, input bit px0, input bit flush5, input bit ufl);
      cyc1(0, 0);
      if (flush5) watch_first = 1;
      cyc1(0, 0);
      cyc1(0, 0);
      if (flush5) begin
         rv_hold = 0;
         ack_force0 = 0;
      end
      for (int i = 0; i < 14; i++) begin
         cyc1(0, 1);
         if (stall && i == 4) ack_force0 = 1;
         if (stall && i == 7) ack_force0 = 0;
      end
      for (int l = 0; l < VD; l++) begin
         for (int p = 0; p < HD; p++) begin
            cyc1(1, 1);
            if (l == 0 && p == 0) begin
               if (ufl) rv_hold = 1;
               if (px0) begin
                  @(negedge CLK);
                  chk("px0", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
               end
            end
            if (ufl && l == 0 && p == HD-1) begin
               @(negedge CLK);
               chk("uf_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, UFC});
            end
         end
         if (l == 0 && ufl) rv_hold = 0;
         repeat (4) cyc1(0, 1);
      end
   endtask

   initial begin
      bit got5;
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got5;
      // reset, then idle with no VS edge: no requests
      RST = 0;
      repeat (3) cyc1(0, 1);
      @(posedge CLK); #1; RST = 1;
      repeat (5) cyc1(0, 1);
      @(negedge CLK);
      chk("idle_req", 32'(MEM_REQ), 0);

      // normal frames, 2-cycle latency, always-ack; one with an ack stall
      frame(0, 1, 0, 0);
      frame(1, 1, 0, 0);
      lines(15);                       // runs well past the last address
      frame(0, 1, 0, 0);
      @(negedge CLK);
      chk("uf_clean", 32'(UNDERFLOW), 0);

      // VS edge with exactly 5 requests outstanding
      repeat (3) cyc1(0, 0);
      got5 = 0;
      for (int k = 0; k < 60; k++) begin
         cyc1(0, 1);
         @(negedge CLK); #1;
         if (!in_flush) rv_hold = 1;
         if (rv_hold && fresh_cnt == 5) begin
            got5 = 1;
            break;
         end
      end
      if (!got5) chk("outst5_wait", 32'(fresh_cnt), 5);
      ack_force0 = 1;
      frame(0, 1, 1, 0);
      chk("flush_seen", 32'(watch_first), 0);
      chk("flush_addr0", 32'(first_acc), 0);

      // underflow and its stickiness
      frame(0, 1, 0, 1);
      @(negedge CLK);
      chk("uf_set", 32'(UNDERFLOW), 1);
      frame(0, 1, 0, 0);
      @(negedge CLK);
      chk("uf_sticky", 32'(UNDERFLOW), 1);

      // random ack / response timing
      ack_rand = 1;
      rv_rand  = 1;
      frame(0, 0, 0, 0);
      frame(0, 0, 0, 0);
      ack_rand = 0;
      rv_rand  = 0;

      // one-cycle reset mid-line, then a stale response
      repeat (3) cyc1(0, 0);
      repeat (14) cyc1(0, 1);
      repeat (5) cyc1(1, 1);
      @(posedge CLK); #1; RST = 0; VGA_BLANK = 0;
      @(posedge CLK); #1; RST = 1; inject_rv = 1;
      @(negedge CLK);
      chk("rst_mid_req", 32'(MEM_REQ), 0);
      chk("rst_mid_uf", 32'(UNDERFLOW), 0);
      repeat (8) cyc1(0, 1);
      @(negedge CLK);
      chk("rst_idle_req", 32'(MEM_REQ), 0);
      frame(0, 1, 0, 0);
      @(negedge CLK);
      chk("uf_after_rst", 32'(UNDERFLOW), 0);

      repeat (4) cyc1(0, 1);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
